// File: rtl/stage_mem_pkg.sv
// rtl/stage_mem_pkg.sv - shared encodings for the memory stage
package stage_mem_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUS  = 1'b1
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_ALL = 4'b1111;
    localparam logic [3:0] BE_LO  = 4'b0011;
    localparam logic [3:0] BE_HI  = 4'b1100;

    // Unsigned variants exist only for loads; alignment follows access size.
    function automatic logic access_legal(input logic we, input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            F3_BU:   ok = ~we;
            F3_HU:   ok = ~we & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte-lane formatting for stores and extraction for loads
module mem_align
    import stage_mem_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        wdata_o = '0;
        be_o    = BE_ALL;
        if (we_i) begin
            case (funct3_i)
                F3_B: begin
                    wdata_o = {4{wdata_i[7:0]}};
                    be_o    = 4'b0001 << addr_lo_i;
                end
                F3_H: begin
                    wdata_o = {2{wdata_i[15:0]}};
                    be_o    = addr_lo_i[1] ? BE_HI : BE_LO;
                end
                default: wdata_o = wdata_i;
            endcase
        end
    end

    assign rbyte = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign rhalf = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        case (funct3_i)
            F3_B:    rdata_o = {{24{rbyte[7]}}, rbyte};
            F3_BU:   rdata_o = {24'b0, rbyte};
            F3_H:    rdata_o = {{16{rhalf[15]}}, rhalf};
            F3_HU:   rdata_o = {16'b0, rhalf};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// rtl/stage_mem.sv - memory pipeline stage: load/store bus FSM with timeout and writeback
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_mem_req,
    input  logic        i_mem_we,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic [2:0]  i_funct3,
    input  logic        i_reg_we,
    input  logic [4:0]  i_reg_waddr,
    input  logic [31:0] i_reg_wdata,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic        o_reg_we,
    output logic [4:0]  o_reg_waddr,
    output logic [31:0] o_reg_wdata,
    output logic        o_hold_flag,
    output logic        o_misalign,
    output logic        o_bus_err
);

    // Counter only needs to reach TIMEOUT-1; the abort happens on that cycle.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [4:0]    waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          reg_we_q, reg_we_d;
    logic [4:0]    reg_waddr_q, reg_waddr_d;
    logic [31:0]   reg_wdata_q, reg_wdata_d;
    logic          misalign_q, misalign_d;
    logic          bus_err_q, bus_err_d;

    logic          in_bus;
    logic          legal;
    logic [31:0]   fmt_wdata;
    logic [3:0]    fmt_be;
    logic [31:0]   ext_rdata;

    assign in_bus = (state_q == S_BUS);
    assign legal  = access_legal(i_mem_we, i_funct3, i_mem_addr[1:0]);

    // One aligner serves both directions: formatting in IDLE, extraction in BUS.
    mem_align u_align (
        .we_i      (i_mem_we),
        .funct3_i  (in_bus ? funct3_q : i_funct3),
        .addr_lo_i (in_bus ? addr_q[1:0] : i_mem_addr[1:0]),
        .wdata_i   (i_mem_wdata),
        .rdata_i   (i_bus_rdata),
        .wdata_o   (fmt_wdata),
        .be_o      (fmt_be),
        .rdata_o   (ext_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        reg_we_d    = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        o_hold_flag = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!i_mem_req) begin
                    reg_we_d    = i_reg_we;
                    reg_waddr_d = i_reg_waddr;
                    reg_wdata_d = i_reg_wdata;
                end else if (legal) begin
                    o_hold_flag = 1'b1;
                    state_d     = S_BUS;
                    cnt_d       = '0;
                    addr_d      = i_mem_addr;
                    we_d        = i_mem_we;
                    funct3_d    = i_funct3;
                    waddr_d     = i_reg_waddr;
                    wdata_d     = fmt_wdata;
                    be_d        = fmt_be;
                end else begin
                    misalign_d = 1'b1;
                end
            end
            S_BUS: begin
                o_hold_flag = ~i_bus_ack;
                if (i_bus_ack) begin
                    state_d = S_IDLE;
                    if (!we_q) begin
                        reg_we_d    = 1'b1;
                        reg_waddr_d = waddr_q;
                        reg_wdata_d = ext_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_IDLE;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign o_bus_req   = in_bus;
    assign o_bus_we    = in_bus & we_q;
    assign o_bus_addr  = in_bus ? {addr_q[31:2], 2'b00} : '0;
    assign o_bus_wdata = in_bus ? wdata_q : '0;
    assign o_bus_be    = in_bus ? be_q : '0;
    assign o_reg_we    = reg_we_q;
    assign o_reg_waddr = reg_waddr_q;
    assign o_reg_wdata = reg_wdata_q;
    assign o_misalign  = misalign_q;
    assign o_bus_err   = bus_err_q;

endmodule

// File: tb/tb_stage_mem.sv
// tb/tb_stage_mem.sv - randomized and directed checks of stage_mem against a behavioural model
module tb_stage_mem;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        i_mem_req, i_mem_we;
    logic [31:0] i_mem_addr, i_mem_wdata;
    logic [2:0]  i_funct3;
    logic        i_reg_we;
    logic [4:0]  i_reg_waddr;
    logic [31:0] i_reg_wdata;
    logic        o_bus_req, o_bus_we;
    logic [31:0] o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;
    logic        o_reg_we;
    logic [4:0]  o_reg_waddr;
    logic [31:0] o_reg_wdata;
    logic        o_hold_flag, o_misalign, o_bus_err;

    stage_mem #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_mem_req(i_mem_req), .i_mem_we(i_mem_we), .i_mem_addr(i_mem_addr),
        .i_mem_wdata(i_mem_wdata), .i_funct3(i_funct3),
        .i_reg_we(i_reg_we), .i_reg_waddr(i_reg_waddr), .i_reg_wdata(i_reg_wdata),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
        .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be),
        .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata),
        .o_reg_we(o_reg_we), .o_reg_waddr(o_reg_waddr), .o_reg_wdata(o_reg_wdata),
        .o_hold_flag(o_hold_flag), .o_misalign(o_misalign), .o_bus_err(o_bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic last_hold;

    // Reference model: one outstanding access record plus expected registered outputs.
    bit        m_busy = 0;
    int        m_wait = 0;
    bit [31:0] m_addr = 0, m_wd = 0;
    bit        m_we = 0;
    bit [2:0]  m_f3 = 0;
    bit [4:0]  m_waddr = 0;
    bit        e_reg_we = 0, e_mis = 0, e_err = 0;
    bit [4:0]  e_reg_waddr = 0;
    bit [31:0] e_reg_wdata = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_legal(input bit we, input bit [2:0] f3, input bit [31:0] a);
        int nbytes;
        if (f3 == 3'd3 || f3 >= 3'd6) return 1'b0;
        if (we && f3 >= 3'd4) return 1'b0;
        nbytes = 1 << f3[1:0];
        return (a % 32'(nbytes)) == 0;
    endfunction

    function automatic bit [3:0] m_be(input bit we, input bit [2:0] f3, input bit [31:0] a);
        if (!we || f3 == 3'd2) return 4'hF;
        if (f3 == 3'd0) return 4'(1 << a[1:0]);
        return a[1] ? 4'hC : 4'h3;
    endfunction

    function automatic bit [31:0] m_wdata(input bit we, input bit [2:0] f3, input bit [31:0] d);
        if (!we) return 32'd0;
        if (f3 == 3'd0) return 32'(d[7:0]) * 32'h01010101;
        if (f3 == 3'd1) return 32'(d[15:0]) * 32'h00010001;
        return d;
    endfunction

    function automatic bit [31:0] m_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] r);
        bit [31:0] sh, v;
        sh = r >> (8 * a[1:0]);
        case (f3)
            3'd0: begin v = sh & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
            3'd4: v = sh & 32'hFF;
            3'd1: begin v = sh & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
            3'd5: v = sh & 32'hFFFF;
            default: v = r;
        endcase
        return v;
    endfunction

    // One clock cycle: check combinational hold, advance the model, check registered outputs.
    task automatic step();
        bit exp_hold;
        #1;
        exp_hold = m_busy ? !i_bus_ack : (i_mem_req && m_legal(i_mem_we, i_funct3, i_mem_addr));
        last_hold = o_hold_flag;
        chk("hold_flag", 32'(o_hold_flag), 32'(exp_hold));
        e_mis = 0;
        e_err = 0;
        if (rst) begin
            m_busy = 0;
            e_reg_we = 0;
        end else if (!m_busy) begin
            if (!i_mem_req) begin
                e_reg_we = i_reg_we;
                e_reg_waddr = i_reg_waddr;
                e_reg_wdata = i_reg_wdata;
            end else if (m_legal(i_mem_we, i_funct3, i_mem_addr)) begin
                m_busy = 1; m_wait = 0;
                m_addr = i_mem_addr; m_we = i_mem_we; m_f3 = i_funct3;
                m_wd = i_mem_wdata; m_waddr = i_reg_waddr;
                e_reg_we = 0;
            end else begin
                e_mis = 1;
                e_reg_we = 0;
            end
        end else begin
            e_reg_we = 0;
            if (i_bus_ack) begin
                m_busy = 0;
                if (!m_we) begin
                    e_reg_we = 1;
                    e_reg_waddr = m_waddr;
                    e_reg_wdata = m_load(m_f3, m_addr, i_bus_rdata);
                end
            end else begin
                m_wait++;
                if (m_wait == TO) begin
                    m_busy = 0;
                    e_err = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("bus_req", 32'(o_bus_req), 32'(m_busy));
        chk("bus_we", 32'(o_bus_we), 32'(m_busy && m_we));
        chk("bus_addr", o_bus_addr, m_busy ? (m_addr & ~32'd3) : 32'd0);
        chk("bus_wdata", o_bus_wdata, m_busy ? m_wdata(m_we, m_f3, m_wd) : 32'd0);
        chk("bus_be", 32'(o_bus_be), m_busy ? 32'(m_be(m_we, m_f3, m_addr)) : 32'd0);
        chk("reg_we", 32'(o_reg_we), 32'(e_reg_we));
        chk("misalign", 32'(o_misalign), 32'(e_mis));
        chk("bus_err", 32'(o_bus_err), 32'(e_err));
        if (e_reg_we) begin
            chk("reg_waddr", 32'(o_reg_waddr), 32'(e_reg_waddr));
            chk("reg_wdata", o_reg_wdata, e_reg_wdata);
        end
    endtask

    task automatic set_mem(input logic req, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] f3, input logic [4:0] rd);
        i_mem_req = req; i_mem_we = we; i_mem_addr = a; i_mem_wdata = d;
        i_funct3 = f3; i_reg_waddr = rd; i_reg_we = 1'b0; i_reg_wdata = 32'd0;
    endtask

    int hc;

    initial begin
        rst = 1'b1; i_bus_ack = 1'b0; i_bus_rdata = 32'd0;
        set_mem(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 5'd0);
        @(posedge clk);
        #1;
        step();
        chk("rst_bus_req", 32'(o_bus_req), 32'd0);
        chk("rst_reg_we", 32'(o_reg_we), 32'd0);
        chk("rst_bus_addr", o_bus_addr, 32'd0);
        chk("rst_reg_wdata", o_reg_wdata, 32'd0);
        rst = 1'b0;

        // SW with two wait cycles
        set_mem(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 5'd3);
        hc = 0;
        step(); hc += int'(last_hold);
        chk("sw_be", 32'(o_bus_be), 32'hF);
        chk("sw_addr", o_bus_addr, 32'h100);
        chk("sw_wdata", o_bus_wdata, 32'hDEADBEEF);
        step(); hc += int'(last_hold);
        step(); hc += int'(last_hold);
        i_bus_ack = 1'b1;
        step(); hc += int'(last_hold);
        chk("sw_hold_cycles", 32'(hc), 32'd3);
        chk("sw_no_wb", 32'(o_reg_we), 32'd0);
        i_bus_ack = 1'b0; i_mem_req = 1'b0;
        step();

        // LB / LBU from lane 3, immediate ack
        set_mem(1'b1, 1'b0, 32'h203, 32'd0, 3'b000, 5'd9);
        step();
        i_bus_ack = 1'b1; i_bus_rdata = 32'h80123456;
        step();
        chk("lb_we", 32'(o_reg_we), 32'd1);
        chk("lb_data", o_reg_wdata, 32'hFFFFFF80);
        chk("lb_waddr", 32'(o_reg_waddr), 32'd9);
        i_bus_ack = 1'b0; i_funct3 = 3'b100;
        step();
        i_bus_ack = 1'b1;
        step();
        chk("lbu_data", o_reg_wdata, 32'h00000080);
        i_bus_ack = 1'b0; i_mem_req = 1'b0;
        step();

        // SH upper half, then misaligned LH
        set_mem(1'b1, 1'b1, 32'h102, 32'h0000ABCD, 3'b001, 5'd0);
        step();
        chk("sh_be", 32'(o_bus_be), 32'hC);
        chk("sh_wdata", o_bus_wdata, 32'hABCDABCD);
        i_bus_ack = 1'b1;
        step();
        i_bus_ack = 1'b0;
        set_mem(1'b1, 1'b0, 32'h101, 32'd0, 3'b001, 5'd4);
        step();
        chk("lh_misalign", 32'(o_misalign), 32'd1);
        chk("lh_no_req", 32'(o_bus_req), 32'd0);
        i_mem_req = 1'b0;
        step();
        chk("lh_pulse_end", 32'(o_misalign), 32'd0);

        // LW timeout
        set_mem(1'b1, 1'b0, 32'h300, 32'd0, 3'b010, 5'd5);
        hc = 0;
        step(); hc += int'(o_bus_req);
        i_mem_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(); hc += int'(o_bus_req);
        end
        step();
        chk("to_req_cycles", 32'(hc), 32'd4);
        chk("to_err", 32'(o_bus_err), 32'd1);
        chk("to_no_wb", 32'(o_reg_we), 32'd0);
        step();
        chk("to_err_end", 32'(o_bus_err), 32'd0);

        // Ack on the last allowed cycle beats the timeout
        set_mem(1'b1, 1'b0, 32'h304, 32'd0, 3'b010, 5'd6);
        step();
        i_mem_req = 1'b0;
        for (int k = 0; k < 3; k++) step();
        i_bus_ack = 1'b1; i_bus_rdata = 32'h12345678;
        step();
        chk("late_ack_wb", o_reg_wdata, 32'h12345678);
        chk("late_ack_noerr", 32'(o_bus_err), 32'd0);
        i_bus_ack = 1'b0;

        // Plain writeback, including x0
        set_mem(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 5'd7);
        i_reg_we = 1'b1; i_reg_wdata = 32'h5;
        step();
        chk("alu_wdata", o_reg_wdata, 32'h5);
        chk("alu_waddr", 32'(o_reg_waddr), 32'd7);
        i_reg_waddr = 5'd0;
        step();
        chk("x0_we", 32'(o_reg_we), 32'd1);

        // Reset mid-access, then a stray ack
        set_mem(1'b1, 1'b0, 32'h400, 32'd0, 3'b010, 5'd8);
        step();
        rst = 1'b1; i_mem_req = 1'b0;
        step();
        chk("rst_mid_req", 32'(o_bus_req), 32'd0);
        rst = 1'b0; i_bus_ack = 1'b1;
        step();
        chk("stray_ack_wb", 32'(o_reg_we), 32'd0);
        i_bus_ack = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            i_mem_req   = 1'($urandom_range(0, 1));
            i_mem_we    = 1'($urandom_range(0, 1));
            i_funct3    = 3'($urandom_range(0, 7));
            i_mem_addr  = $urandom();
            if ($urandom_range(0, 2) != 0) i_mem_addr[1:0] = 2'b00;
            i_mem_wdata = $urandom();
            i_reg_we    = 1'($urandom_range(0, 1));
            i_reg_waddr = 5'($urandom_range(0, 31));
            i_reg_wdata = $urandom();
            i_bus_ack   = ($urandom_range(0, 99) < 30);
            i_bus_rdata = $urandom();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
